switch_input_ctrl: RTL and testbench

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

---
 rtl/switch_input_ctrl_if.sv | 11 +
 rtl/switch_input_ctrl.sv | 74 +++++++
 tb/tb_switch_input_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/switch_input_ctrl_if.sv
// switch_input_ctrl_if: IO bus between the memory/IO mux stage and the switch input block
// master: drives switch_ctrl (chip select), io_read (read strobe), io_addr (byte offset); samples io_rdata
// slave : samples switch_ctrl, io_read, io_addr; drives io_rdata
interface switch_input_ctrl_if;
  logic        switch_ctrl;
  logic        io_read;
  logic [3:0]  io_addr;
  logic [15:0] io_rdata;
  modport master (output switch_ctrl, io_read, io_addr, input io_rdata);
  modport slave (input switch_ctrl, io_read, io_addr, output io_rdata);
endinterface

// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: debounced confirm button latches the board switches for IO reads
// clk, rst        : clock, asynchronous active-high reset
// bus (slave)     : switch_ctrl/io_read/io_addr select a register, io_rdata returns it combinationally
// sw_in           : raw board switches (asynchronous)
// confirm_btn     : raw confirm push-button (asynchronous, active-high)
// data_ready      : a latched switch value is waiting to be read (also drives an LED)
module switch_input_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  switch_input_ctrl_if.slave bus,
  input  logic [15:0]        sw_in,
  input  logic               confirm_btn,
  output logic               data_ready
);
  typedef enum logic {IDLE, READY} state_t;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
  logic [15:0] sw_meta_q, sw_sync_q, sw_latched_q;
  logic btn_meta_q, btn_sync_q, btn_stable_q, btn_stable_d, btn_prev_q, press_pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t state_q;
  logic data_ready_q, sel, data_rd;
  assign sel        = bus.switch_ctrl & bus.io_read;
  assign data_rd    = sel & (bus.io_addr == 4'h0);
  assign data_ready = data_ready_q;
  assign bus.io_rdata = !sel                 ? 16'h0000 :
                        bus.io_addr == 4'h0 ? sw_latched_q :
                        bus.io_addr == 4'h2 ? {15'b0, data_ready_q} :
                        bus.io_addr == 4'h4 ? sw_sync_q : 16'h0000;
  // The counter runs only while the synchronized level disagrees with the accepted one;
  // on the DEB_CYCLES-th disagreeing sample the new level is accepted.
  always_comb begin
    cnt_d        = (btn_sync_q == btn_stable_q || cnt_q == DEB_MAX) ? '0 : cnt_q + 1'b1;
    btn_stable_d = (btn_sync_q != btn_stable_q && cnt_q == DEB_MAX) ? btn_sync_q : btn_stable_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      cnt_q         <= '0;
      btn_stable_q  <= 1'b0;
      btn_prev_q    <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      sw_meta_q     <= sw_in;
      sw_sync_q     <= sw_meta_q;
      btn_meta_q    <= confirm_btn;
      btn_sync_q    <= btn_meta_q;
      cnt_q         <= cnt_d;
      btn_stable_q  <= btn_stable_d;
      btn_prev_q    <= btn_stable_q;
      press_pulse_q <= btn_stable_q & ~btn_prev_q;
    end
  end
  // A press always wins over a coinciding read: the read sees the old value, the new one latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_ready_q <= 1'b0;
      sw_latched_q <= '0;
    end else if (press_pulse_q) begin
      state_q      <= READY;
      data_ready_q <= 1'b1;
      sw_latched_q <= sw_sync_q;
    end else if (state_q == READY && data_rd) begin
      state_q      <= IDLE;
      data_ready_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_switch_input_ctrl.sv
// tb_switch_input_ctrl: directed scenarios plus randomized traffic checked against a behavioural model
module tb_switch_input_ctrl;
  localparam int DEB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sw_in = '0;
  logic confirm_btn = 1'b0;
  logic data_ready;
  int asserts = 0;
  int fails = 0;
  switch_input_ctrl_if bus();
  switch_input_ctrl #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw_in(sw_in), .confirm_btn(confirm_btn), .data_ready(data_ready)
  );
  always #5 clk = ~clk;
  // Behavioural model: inputs reach the logic two edges late; the accepted button level flips once
  // the last DEB synchronized samples all disagree with it; a rise reaches the latch two edges later.
  logic [15:0] m_sw1, m_sw2, m_latched;
  logic m_b1, m_b2, m_stable, m_ready;
  bit m_win[$];
  int m_n, m_fsm_edge, m_diff;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sw1 = '0; m_sw2 = '0; m_latched = '0;
      m_b1 = 0; m_b2 = 0; m_stable = 0; m_ready = 0;
      m_win.delete(); m_n = 0; m_fsm_edge = -1;
    end else begin
      m_n++;
      if (m_n == m_fsm_edge) begin
        m_latched = m_sw2;
        m_ready = 1;
      end else if (bus.switch_ctrl && bus.io_read && bus.io_addr == 4'h0) m_ready = 0;
      m_win.push_back(m_b2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      m_diff = 0;
      foreach (m_win[i]) m_diff += int'(m_win[i] != m_stable);
      if (m_diff == DEB) begin
        m_stable = !m_stable;
        m_win.delete();
        if (m_stable) m_fsm_edge = m_n + 2;
      end
      m_sw2 = m_sw1; m_sw1 = sw_in;
      m_b2 = m_b1; m_b1 = confirm_btn;
    end
  end
  function automatic logic [15:0] exp_rdata();
    if (!(bus.switch_ctrl && bus.io_read)) return 16'h0000;
    case (bus.io_addr)
      4'h0: return m_latched;
      4'h2: return {15'b0, m_ready};
      4'h4: return m_sw2;
      default: return 16'h0000;
    endcase
  endfunction
  task automatic bus_set(input logic sc, input logic ir, input logic [3:0] a);
    bus.switch_ctrl = sc; bus.io_read = ir; bus.io_addr = a;
  endtask
  task automatic test_reset();
    rst = 1; confirm_btn = 0; sw_in = 16'h5A5A; bus_set(1, 1, 4'h0);
    repeat (3) @(negedge clk);
    asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", data_ready); end
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rd0: got %h want 0000", bus.io_rdata); end
    bus_set(1, 1, 4'h2); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rd2: got %h want 0000", bus.io_rdata); end
    bus_set(1, 1, 4'h4); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rd4: got %h want 0000", bus.io_rdata); end
    bus_set(0, 0, 4'h0); rst = 0;
    repeat (4) @(negedge clk);
    asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL post_reset_ready: got %b want 0", data_ready); end
    bus_set(1, 1, 4'h0); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL post_reset_rd0: got %h want 0000", bus.io_rdata); end
    bus_set(1, 1, 4'h2); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL post_reset_rd2: got %h want 0000", bus.io_rdata); end
    bus_set(0, 0, 4'h0);
  endtask
  task automatic test_clean_press();
    sw_in = 16'hA5C3; confirm_btn = 1;
    for (int c = 1; c <= DEB + 4; c++) begin
      @(negedge clk);
      asserts++; if (data_ready !== (c == DEB + 4)) begin fails++; $display("FAIL press_latency c%0d: got %b want %b", c, data_ready, c == DEB + 4); end
    end
    bus_set(1, 1, 4'h0); #1;
    asserts++; if (bus.io_rdata !== 16'hA5C3) begin fails++; $display("FAIL press_read: got %h want a5c3", bus.io_rdata); end
    @(negedge clk); bus_set(0, 0, 4'h0);
    asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL read_clears: got %b want 0", data_ready); end
    confirm_btn = 0;
    repeat (DEB + 6) @(negedge clk);
    asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL release_no_latch: got %b want 0", data_ready); end
  endtask
  task automatic test_glitch();
    confirm_btn = 1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) confirm_btn = 0;
      @(negedge clk);
      asserts++; if (dut.btn_stable_q !== 1'b0 || data_ready !== 1'b0) begin fails++; $display("FAIL glitch c%0d: stable %b ready %b want 0 0", c, dut.btn_stable_q, data_ready); end
    end
  endtask
  task automatic test_simultaneous();
    sw_in = 16'h1111; confirm_btn = 1;
    repeat (DEB + 4) @(negedge clk);
    confirm_btn = 0;
    repeat (DEB + 4) @(negedge clk);
    asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL sim_ready1: got %b want 1", data_ready); end
    sw_in = 16'h2222; confirm_btn = 1;
    repeat (DEB + 3) @(negedge clk);
    bus_set(1, 1, 4'h0); #1;
    asserts++; if (bus.io_rdata !== 16'h1111) begin fails++; $display("FAIL sim_old: got %h want 1111", bus.io_rdata); end
    @(negedge clk);
    asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL sim_stay_ready: got %b want 1", data_ready); end
    asserts++; if (bus.io_rdata !== 16'h2222) begin fails++; $display("FAIL sim_new: got %h want 2222", bus.io_rdata); end
    bus_set(0, 0, 4'h0); confirm_btn = 0;
    repeat (DEB + 4) @(negedge clk);
  endtask
  task automatic test_unmapped();
    bus_set(0, 1, 4'h0); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL unsel_rd: got %h want 0000", bus.io_rdata); end
    @(negedge clk);
    asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL unsel_state: got %b want 1", data_ready); end
    bus_set(1, 1, 4'h6); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL unmapped_rd: got %h want 0000", bus.io_rdata); end
    @(negedge clk);
    asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL unmapped_state: got %b want 1", data_ready); end
    bus_set(1, 0, 4'h0); #1;
    asserts++; if (bus.io_rdata !== 16'h0000) begin fails++; $display("FAIL noread_rd: got %h want 0000", bus.io_rdata); end
    @(negedge clk);
    bus_set(1, 1, 4'h2); #1;
    asserts++; if (bus.io_rdata !== 16'h0001) begin fails++; $display("FAIL status_rd: got %h want 0001", bus.io_rdata); end
    @(negedge clk);
    asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL status_state: got %b want 1", data_ready); end
    bus_set(0, 0, 4'h0);
  endtask
  task automatic test_live_sw();
    sw_in = 16'hBEEF; bus_set(1, 1, 4'h4);
    @(negedge clk);
    asserts++; if (bus.io_rdata !== 16'h2222) begin fails++; $display("FAIL live_1cyc: got %h want 2222", bus.io_rdata); end
    @(negedge clk);
    asserts++; if (bus.io_rdata !== 16'hBEEF) begin fails++; $display("FAIL live_2cyc: got %h want beef", bus.io_rdata); end
    asserts++; if (data_ready !== 1'b1) begin fails++; $display("FAIL live_state: got %b want 1", data_ready); end
    bus_set(1, 1, 4'h0);
    @(negedge clk); bus_set(0, 0, 4'h0);
    asserts++; if (data_ready !== 1'b0) begin fails++; $display("FAIL live_consume: got %b want 0", data_ready); end
  endtask
  task automatic test_hold();
    int latches = 0;
    sw_in = 16'h3C3C; confirm_btn = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (data_ready) begin
        latches++;
        bus_set(1, 1, 4'h0);
        @(negedge clk);
        bus_set(0, 0, 4'h0);
      end
    end
    asserts++; if (latches !== 1) begin fails++; $display("FAIL hold_latches: got %0d want 1", latches); end
    confirm_btn = 0;
    repeat (DEB + 4) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    sw_in = 16'h0F0F; confirm_btn = 1;
    repeat (4) @(negedge clk);
    asserts++; if (dut.cnt_q !== 3'd2) begin fails++; $display("FAIL mid_count: got %0d want 2", dut.cnt_q); end
    rst = 1;
    @(negedge clk);
    asserts++; if (dut.cnt_q !== 3'd0 || data_ready !== 1'b0) begin fails++; $display("FAIL mid_reset: cnt %0d ready %b want 0 0", dut.cnt_q, data_ready); end
    sw_in = 16'hF0F0; rst = 0;
    for (int c = 1; c <= DEB + 4; c++) begin
      @(negedge clk);
      asserts++; if (data_ready !== (c == DEB + 4)) begin fails++; $display("FAIL mid_latency c%0d: got %b want %b", c, data_ready, c == DEB + 4); end
    end
    bus_set(1, 1, 4'h0); #1;
    asserts++; if (bus.io_rdata !== 16'hF0F0) begin fails++; $display("FAIL mid_value: got %h want f0f0", bus.io_rdata); end
    @(negedge clk); bus_set(0, 0, 4'h0); confirm_btn = 0;
    repeat (DEB + 4) @(negedge clk);
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      asserts++; if (data_ready !== m_ready) begin fails++; $display("FAIL rand_ready i%0d: got %b want %b", i, data_ready, m_ready); end
      if ($urandom_range(7) == 0) confirm_btn = ~confirm_btn;
      if ($urandom_range(3) == 0) sw_in = 16'($urandom);
      bus_set(1'($urandom), 1'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'(2 * $urandom_range(2)));
      #1;
      asserts++; if (bus.io_rdata !== exp_rdata()) begin fails++; $display("FAIL rand_rdata i%0d addr %h: got %h want %h", i, bus.io_addr, bus.io_rdata, exp_rdata()); end
    end
    bus_set(0, 0, 4'h0);
  endtask
  initial begin
    bus_set(0, 0, 4'h0);
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_unmapped();
    test_live_sw();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
